// File: rtl/clb_serial_subtractor_if.sv
// Handshake and operand/result bundle for the CLB serial subtractor.
// The ovf signal exists only when CLB_SUB_OVF_EN is defined.
interface clb_serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] minuend;
   logic [WIDTH-1:0] subtrahend;
   logic             B_In;
   logic [WIDTH-1:0] difference;
   logic             B_Out;
   logic             busy;
   logic             done;
`ifdef CLB_SUB_OVF_EN
   logic             ovf;
`endif

   // Controller side drives the request and operands, then observes the result.
   modport master (
      output start,
      output minuend,
      output subtrahend,
      output B_In,
      input  difference,
      input  B_Out,
      input  busy,
      input  done
`ifdef CLB_SUB_OVF_EN
      ,
      input  ovf
`endif
   );

   modport slave (
      input  start,
      input  minuend,
      input  subtrahend,
      input  B_In,
      output difference,
      output B_Out,
      output busy,
      output done
`ifdef CLB_SUB_OVF_EN
      ,
      output ovf
`endif
   );
endinterface

// File: rtl/clb_serial_subtractor.sv
// Multi-cycle subtractor: minuend - subtrahend - B_In, two bits per clock, LSB slice first.
// Optional signed-overflow output enabled by defining CLB_SUB_OVF_EN.
module clb_serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic                    clock,
   input logic                    reset,
   clb_serial_subtractor_if.slave bus
);
   localparam int SLICES = WIDTH / 2;
   localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] aOp_q, aOp_d;
   logic [WIDTH-1:0] bOp_q, bOp_d;
   logic             borrow_q, borrow_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] difference_q, difference_d;
   logic             bOut_q, bOut_d;
`ifdef CLB_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [1:0] aSlice;
   logic [1:0] bSlice;
   logic [2:0] sliceDiff;
   logic       msbBorrowIn;
   logic       lastSlice;

   // Bit 2 of the 3-bit slice result is the borrow out of the slice; the
   // borrow out of its low bit is the borrow into the MSB when this is the top slice.
   always_comb begin
      aSlice      = aOp_q[{index_q, 1'b0} +: 2];
      bSlice      = bOp_q[{index_q, 1'b0} +: 2];
      sliceDiff   = {1'b0, aSlice} - {1'b0, bSlice} - {2'b00, borrow_q};
      msbBorrowIn = (~aSlice[0] & bSlice[0]) | (~(aSlice[0] ^ bSlice[0]) & borrow_q);
      lastSlice   = (index_q == IDX_W'(SLICES - 1));
   end

   always_comb begin
      state_d      = state_q;
      aOp_d        = aOp_q;
      bOp_d        = bOp_q;
      borrow_d     = borrow_q;
      index_d      = index_q;
      result_d     = result_q;
      difference_d = difference_q;
      bOut_d       = bOut_q;
`ifdef CLB_SUB_OVF_EN
      ovf_d        = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               aOp_d    = bus.minuend;
               bOp_d    = bus.subtrahend;
               borrow_d = bus.B_In;
               index_d  = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[{index_q, 1'b0} +: 2] = sliceDiff[1:0];
            borrow_d = sliceDiff[2];
            index_d  = index_q + IDX_W'(1);
            if (lastSlice) begin
               difference_d = result_d;
               bOut_d       = sliceDiff[2];
`ifdef CLB_SUB_OVF_EN
               ovf_d        = msbBorrowIn ^ sliceDiff[2];
`endif
               index_d      = '0;
               state_d      = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         aOp_q        <= '0;
         bOp_q        <= '0;
         borrow_q     <= 1'b0;
         index_q      <= '0;
         result_q     <= '0;
         difference_q <= '0;
         bOut_q       <= 1'b0;
`ifdef CLB_SUB_OVF_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         aOp_q        <= aOp_d;
         bOp_q        <= bOp_d;
         borrow_q     <= borrow_d;
         index_q      <= index_d;
         result_q     <= result_d;
         difference_q <= difference_d;
         bOut_q       <= bOut_d;
`ifdef CLB_SUB_OVF_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign bus.difference = difference_q;
   assign bus.B_Out      = bOut_q;
   assign bus.busy       = (state_q == RUN);
   assign bus.done       = (state_q == DONE);
`ifdef CLB_SUB_OVF_EN
   assign bus.ovf        = ovf_q;
`else
   logic unusedMsbBorrow;
   assign unusedMsbBorrow = msbBorrowIn;
`endif
endmodule

// File: tb/tb_clb_serial_subtractor.sv
// Directed self-checking bench for clb_serial_subtractor at WIDTH=8.
// Define CLB_SUB_OVF_EN to also exercise the overflow output.
module tb_clb_serial_subtractor;
   localparam int WIDTH = 8;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int   busyCount;
   int   doneCount;
   int   doneCycle;
   logic overlapSeen;

   clb_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   clb_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   // Launches one operation and watches 8 cycles; operands are scrambled right
   // after capture, and an optional second start is pulsed at cycle pulseAt.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                input int pulseAt, input logic [7:0] a2, input logic [7:0] b2);
      @(negedge clock);
      bus.start      = 1'b1;
      bus.minuend    = a;
      bus.subtrahend = b;
      bus.B_In       = bin;
      busyCount      = 0;
      doneCount      = 0;
      doneCycle      = -1;
      overlapSeen    = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clock);
         bus.start = (k == pulseAt);
         if (k == 1) begin
            bus.minuend    = ~a;
            bus.subtrahend = ~b;
            bus.B_In       = ~bin;
         end
         if (k == pulseAt) begin
            bus.minuend    = a2;
            bus.subtrahend = b2;
         end
         if (bus.busy) busyCount++;
         if (bus.done) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = k;
         end
         if (bus.busy && bus.done) overlapSeen = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.start      = 1'b0;
      bus.minuend    = '0;
      bus.subtrahend = '0;
      bus.B_In       = 1'b0;
      #1 reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (bus.difference !== 8'h00) begin
         errors++; $display("[TB] FAIL reset_difference got %h expected 00", bus.difference);
      end
      checks++;
      if ({bus.B_Out, bus.busy, bus.done} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_flags got %b expected 000", {bus.B_Out, bus.busy, bus.done});
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      applyStimulus(8'h5A, 8'h3C, 1'b0, 0, 8'h00, 8'h00);
      checks++;
      if (busyCount !== 4) begin
         errors++; $display("[TB] FAIL basic_busy_cycles got %0d expected 4", busyCount);
      end
      checks++;
      if (doneCycle !== 5) begin
         errors++; $display("[TB] FAIL basic_done_timing got cycle %0d expected 5", doneCycle);
      end
      checks++;
      if (doneCount !== 1) begin
         errors++; $display("[TB] FAIL basic_done_count got %0d expected 1", doneCount);
      end
      checks++;
      if (bus.difference !== 8'h1E || bus.B_Out !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_result got %h/%b expected 1e/0", bus.difference, bus.B_Out);
      end
      checks++;
      if (overlapSeen !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_overlap got %b expected 0", overlapSeen);
      end
   endtask

   task automatic test_borrow();
      applyStimulus(8'h00, 8'h01, 1'b0, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'hFF || bus.B_Out !== 1'b1) begin
         errors++; $display("[TB] FAIL borrow_0_minus_1 got %h/%b expected ff/1", bus.difference, bus.B_Out);
      end
      applyStimulus(8'h00, 8'hFF, 1'b1, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'h00 || bus.B_Out !== 1'b1) begin
         errors++; $display("[TB] FAIL borrow_wrap got %h/%b expected 00/1", bus.difference, bus.B_Out);
      end
   endtask

   task automatic test_hold();
      logic stable;
      applyStimulus(8'h10, 8'h0F, 1'b1, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'h00 || bus.B_Out !== 1'b0) begin
         errors++; $display("[TB] FAIL hold_result got %h/%b expected 00/0", bus.difference, bus.B_Out);
      end
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (bus.difference !== 8'h00 || bus.B_Out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         errors++; $display("[TB] FAIL hold_idle_stable got %b expected 1", stable);
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(8'h20, 8'h01, 1'b0, 2, 8'hFF, 8'h00);
      checks++;
      if (doneCount !== 1) begin
         errors++; $display("[TB] FAIL ignored_start_done_count got %0d expected 1", doneCount);
      end
      checks++;
      if (bus.difference !== 8'h1F || bus.B_Out !== 1'b0) begin
         errors++; $display("[TB] FAIL ignored_start_result got %h/%b expected 1f/0", bus.difference, bus.B_Out);
      end
      checks++;
      if (overlapSeen !== 1'b0 || busyCount !== 4) begin
         errors++; $display("[TB] FAIL ignored_start_busy got overlap %b busy %0d expected 0/4", overlapSeen, busyCount);
      end
   endtask

   task automatic test_async_reset();
      int lateDone;
      @(negedge clock);
      bus.start      = 1'b1;
      bus.minuend    = 8'h55;
      bus.subtrahend = 8'h11;
      bus.B_In       = 1'b0;
      @(negedge clock);
      bus.start = 1'b0;
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.difference !== 8'h00) begin
         errors++; $display("[TB] FAIL async_reset_difference got %h expected 00", bus.difference);
      end
      checks++;
      if ({bus.B_Out, bus.busy, bus.done} !== 3'b000) begin
         errors++; $display("[TB] FAIL async_reset_flags got %b expected 000", {bus.B_Out, bus.busy, bus.done});
      end
      @(negedge clock);
      reset = 1'b0;
      lateDone = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (bus.done || bus.busy) lateDone++;
      end
      checks++;
      if (lateDone !== 0) begin
         errors++; $display("[TB] FAIL async_reset_no_done got %0d active cycles expected 0", lateDone);
      end
      applyStimulus(8'h03, 8'h01, 1'b0, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'h02 || doneCount !== 1) begin
         errors++; $display("[TB] FAIL after_reset_result got %h done %0d expected 02 done 1", bus.difference, doneCount);
      end
   endtask

`ifdef CLB_SUB_OVF_EN
   task automatic test_ovf();
      applyStimulus(8'h80, 8'h01, 1'b0, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'h7F || bus.ovf !== 1'b1 || bus.B_Out !== 1'b0) begin
         errors++; $display("[TB] FAIL ovf_80_minus_01 got %h ovf %b bout %b expected 7f/1/0", bus.difference, bus.ovf, bus.B_Out);
      end
      applyStimulus(8'h7F, 8'hFF, 1'b0, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'h80 || bus.ovf !== 1'b1 || bus.B_Out !== 1'b1) begin
         errors++; $display("[TB] FAIL ovf_7f_minus_ff got %h ovf %b bout %b expected 80/1/1", bus.difference, bus.ovf, bus.B_Out);
      end
      applyStimulus(8'h05, 8'h03, 1'b0, 0, 8'h00, 8'h00);
      checks++;
      if (bus.difference !== 8'h02 || bus.ovf !== 1'b0) begin
         errors++; $display("[TB] FAIL ovf_05_minus_03 got %h ovf %b expected 02/0", bus.difference, bus.ovf);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_borrow();
      test_hold();
      test_back_to_back();
      test_async_reset();
`ifdef CLB_SUB_OVF_EN
      test_ovf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
